spi_device_cmd_fsm: RTL and testbench

Parametrised command front-end for the SPI device. It deserialises the opcode, address and dummy phases from the SPI input, decodes a structured opcode space with up to 64 registers, and sequences the data phase. It emits registered control strobes to the register file and memory port, including burst address auto-increment. It sits between the SPI pin interface and the register/memory controllers, all in the sclk domain.

---
 rtl/spi_cmd_pkg.sv | 39 +++
 rtl/spi_device_cmd_fsm_decode.sv | 47 ++++
 rtl/spi_device_cmd_fsm.sv | 209 ++++++++++++++++++++
 tb/tb_spi_device_cmd_fsm.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_pkg.sv
// rtl/spi_cmd_pkg.sv - shared types and opcode constants for the SPI device command front-end
package spi_cmd_pkg;

  // Frame phase, also driven out on state_o
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DUMMY = 3'd2,
    ST_DATA  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  // Operation class held in opcode bits [7:6]
  typedef enum logic [1:0] {
    OP_WR_REG = 2'b00,
    OP_RD_REG = 2'b01,
    OP_WR_MEM = 2'b10,
    OP_RD_MEM = 2'b11
  } op_e;

  // Opcode field layout
  localparam int OP_MSB = 7;
  localparam int OP_LSB = 6;
  localparam int IDX_W  = 6;
  localparam int CMD_W  = 8;

  // Legacy opcode aliases (decoded only when SPI_CMD_LEGACY_EN is defined)
  localparam logic [7:0] LEG_WR_REG0 = 8'h01;
  localparam logic [7:0] LEG_WR_REG1 = 8'h11;
  localparam logic [7:0] LEG_WR_REG2 = 8'h20;
  localparam logic [7:0] LEG_WR_REG3 = 8'h30;
  localparam logic [7:0] LEG_RD_REG0 = 8'h05;
  localparam logic [7:0] LEG_RD_REG1 = 8'h07;
  localparam logic [7:0] LEG_RD_REG2 = 8'h21;
  localparam logic [7:0] LEG_RD_REG3 = 8'h31;
  localparam logic [7:0] LEG_WR_MEM  = 8'h02;
  localparam logic [7:0] LEG_RD_MEM  = 8'h0B;

endpackage

// File: rtl/spi_device_cmd_fsm_decode.sv
// rtl/spi_device_cmd_fsm_decode.sv - combinational opcode decoder (legacy aliases under SPI_CMD_LEGACY_EN)
module spi_cmd_decode
  import spi_cmd_pkg::*;
#(
  parameter int NUM_REGS = 4
) (
  input  logic [CMD_W-1:0] cmd_i,
  output op_e              op_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             legal_o,
  output logic             needs_dummy_o
);

`ifdef SPI_CMD_LEGACY_EN
  localparam bit LEGACY_EN = 1'b1;
`else
  localparam bit LEGACY_EN = 1'b0;
`endif

  // Structured decode first, legacy aliases override it, then legality on the result
  always_comb begin
    op_o  = op_e'(cmd_i[OP_MSB:OP_LSB]);
    idx_o = cmd_i[IDX_W-1:0];
    if (LEGACY_EN) begin
      case (cmd_i)
        LEG_WR_REG0: begin op_o = OP_WR_REG; idx_o = 6'd0; end
        LEG_WR_REG1: begin op_o = OP_WR_REG; idx_o = 6'd1; end
        LEG_WR_REG2: begin op_o = OP_WR_REG; idx_o = 6'd2; end
        LEG_WR_REG3: begin op_o = OP_WR_REG; idx_o = 6'd3; end
        LEG_RD_REG0: begin op_o = OP_RD_REG; idx_o = 6'd0; end
        LEG_RD_REG1: begin op_o = OP_RD_REG; idx_o = 6'd1; end
        LEG_RD_REG2: begin op_o = OP_RD_REG; idx_o = 6'd2; end
        LEG_RD_REG3: begin op_o = OP_RD_REG; idx_o = 6'd3; end
        LEG_WR_MEM:  begin op_o = OP_WR_MEM; idx_o = 6'd0; end
        LEG_RD_MEM:  begin op_o = OP_RD_MEM; idx_o = 6'd0; end
        default: ;
      endcase
    end
    if (op_o == OP_WR_REG || op_o == OP_RD_REG) begin
      legal_o = ({1'b0, idx_o} < 7'(NUM_REGS));
    end else begin
      legal_o = (idx_o == '0);
    end
    needs_dummy_o = (op_o == OP_RD_MEM);
  end

endmodule

// File: rtl/spi_device_cmd_fsm.sv
// rtl/spi_device_cmd_fsm.sv - SPI device command FSM: opcode/addr/dummy/data sequencing (option: SPI_CMD_LEGACY_EN)
module spi_device_cmd_fsm
  import spi_cmd_pkg::*;
#(
  parameter int NUM_REGS  = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int DUMMY_CYC = 8
) (
  input  logic              sclk,
  input  logic              rstn,
  input  logic              cs_n,
  input  logic              sdi,
  output logic [2:0]        state_o,
  output logic [5:0]        reg_sel_o,
  output logic              is_mem_o,
  output logic              is_read_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              addr_valid_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              tx_load_o,
  output logic              error_o
);

  localparam int SH_W    = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_MAX = (SH_W > DUMMY_CYC) ? SH_W : DUMMY_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic [SH_W-1:0]   sh_next;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [5:0]        reg_sel_q, reg_sel_d;
  logic              is_mem_q, is_mem_d;
  logic              is_read_q, is_read_d;
  logic              dummy_q, dummy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              addr_valid_q, addr_valid_d;
  logic              rx_valid_q, rx_valid_d;
  logic              tx_load_q, tx_load_d;

  logic [CMD_W-1:0]  cmd;
  op_e               dec_op;
  logic [IDX_W-1:0]  dec_idx;
  logic              dec_legal;
  logic              dec_dummy;

  // Shift register value including the bit sampled on this edge
  assign sh_next = {sh_q[SH_W-2:0], sdi};
  assign cmd     = sh_next[CMD_W-1:0];

  spi_cmd_decode #(.NUM_REGS(NUM_REGS)) u_decode (
    .cmd_i         (cmd),
    .op_o          (dec_op),
    .idx_o         (dec_idx),
    .legal_o       (dec_legal),
    .needs_dummy_o (dec_dummy)
  );

  // Phase sequencing, counters, decode capture and strobe generation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    sh_d         = sh_next;
    addr_d       = addr_q;
    rx_data_d    = rx_data_q;
    reg_sel_d    = reg_sel_q;
    is_mem_d     = is_mem_q;
    is_read_d    = is_read_q;
    dummy_d      = dummy_q;
    done_d       = done_q;
    err_d        = err_q;
    addr_valid_d = 1'b0;
    rx_valid_d   = 1'b0;
    tx_load_d    = 1'b0;

    if (cs_n) begin
      // Frame end/abort: any partial word is simply dropped with the counter
      state_d   = ST_IDLE;
      cnt_d     = '0;
      sh_d      = '0;
      is_mem_d  = 1'b0;
      is_read_d = 1'b0;
      dummy_d   = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (done_q) begin
            // Register transfer already finished; ignore trailing bits
            cnt_d = cnt_q;
          end else if (cnt_q == CNT_W'(CMD_W - 1)) begin
            cnt_d     = '0;
            reg_sel_d = dec_idx;
            is_mem_d  = dec_op[1];
            is_read_d = dec_op[0];
            dummy_d   = dec_dummy;
            if (!dec_legal) begin
              state_d = ST_ERR;
              err_d   = 1'b1;
            end else if (dec_op[1]) begin
              state_d = ST_ADDR;
            end else begin
              state_d   = ST_DATA;
              tx_load_d = dec_op[0];
            end
          end
        end
        ST_ADDR: begin
          if (cnt_q == CNT_W'(ADDR_W - 1)) begin
            cnt_d        = '0;
            addr_d       = sh_next[ADDR_W-1:0];
            addr_valid_d = 1'b1;
            if (dummy_q && (DUMMY_CYC > 0)) begin
              state_d = ST_DUMMY;
            end else begin
              state_d   = ST_DATA;
              tx_load_d = 1'b1;
            end
          end
        end
        ST_DUMMY: begin
          if (cnt_q == CNT_W'(DUMMY_CYC - 1)) begin
            cnt_d     = '0;
            state_d   = ST_DATA;
            tx_load_d = 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            cnt_d = '0;
            if (!is_read_q) begin
              rx_data_d  = sh_next[DATA_W-1:0];
              rx_valid_d = 1'b1;
            end
            if (is_mem_q) begin
              // Burst continues until cs_n rises; address wraps naturally
              addr_d       = addr_q + ADDR_W'(DATA_W / 8);
              addr_valid_d = 1'b1;
              tx_load_d    = is_read_q;
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
        end
        ST_ERR: begin
          cnt_d = cnt_q;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      sh_q         <= '0;
      addr_q       <= '0;
      rx_data_q    <= '0;
      reg_sel_q    <= '0;
      is_mem_q     <= 1'b0;
      is_read_q    <= 1'b0;
      dummy_q      <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      addr_valid_q <= 1'b0;
      rx_valid_q   <= 1'b0;
      tx_load_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sh_q         <= sh_d;
      addr_q       <= addr_d;
      rx_data_q    <= rx_data_d;
      reg_sel_q    <= reg_sel_d;
      is_mem_q     <= is_mem_d;
      is_read_q    <= is_read_d;
      dummy_q      <= dummy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      addr_valid_q <= addr_valid_d;
      rx_valid_q   <= rx_valid_d;
      tx_load_q    <= tx_load_d;
    end
  end

  assign state_o      = state_q;
  assign reg_sel_o    = reg_sel_q;
  assign is_mem_o     = is_mem_q;
  assign is_read_o    = is_read_q;
  assign addr_o       = addr_q;
  assign addr_valid_o = addr_valid_q;
  assign rx_data_o    = rx_data_q;
  assign rx_valid_o   = rx_valid_q;
  assign tx_load_o    = tx_load_q;
  assign error_o      = err_q;

endmodule

// File: tb/tb_spi_device_cmd_fsm.sv
// tb/tb_spi_device_cmd_fsm.sv - self-checking bench for spi_device_cmd_fsm against a frame-level model
module tb_spi_device_cmd_fsm;

  localparam int NUM_REGS  = 4;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int DUMMY_CYC = 8;

  logic              sclk = 1'b0;
  logic              rstn = 1'b1;
  logic              cs_n = 1'b1;
  logic              sdi  = 1'b0;
  logic [2:0]        state_o;
  logic [5:0]        reg_sel_o;
  logic              is_mem_o;
  logic              is_read_o;
  logic [ADDR_W-1:0] addr_o;
  logic              addr_valid_o;
  logic [DATA_W-1:0] rx_data_o;
  logic              rx_valid_o;
  logic              tx_load_o;
  logic              error_o;

  spi_device_cmd_fsm #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DUMMY_CYC(DUMMY_CYC)
  ) dut (
    .sclk(sclk), .rstn(rstn), .cs_n(cs_n), .sdi(sdi),
    .state_o(state_o), .reg_sel_o(reg_sel_o), .is_mem_o(is_mem_o), .is_read_o(is_read_o),
    .addr_o(addr_o), .addr_valid_o(addr_valid_o), .rx_data_o(rx_data_o),
    .rx_valid_o(rx_valid_o), .tx_load_o(tx_load_o), .error_o(error_o)
  );

  always #5 sclk = ~sclk;

  typedef struct {
    int          edge_n;
    logic [31:0] val;
  } ev_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_rx   = '0;
  logic [5:0]  last_sel  = '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Opcode meaning written straight from the opcode table
  function automatic void model_decode(input logic [7:0] c, output int op, output int idx,
                                       output bit legal);
    op  = int'(c) / 64;
    idx = int'(c) % 64;
`ifdef SPI_CMD_LEGACY_EN
    case (c)
      8'h01: begin op = 0; idx = 0; end
      8'h11: begin op = 0; idx = 1; end
      8'h20: begin op = 0; idx = 2; end
      8'h30: begin op = 0; idx = 3; end
      8'h05: begin op = 1; idx = 0; end
      8'h07: begin op = 1; idx = 1; end
      8'h21: begin op = 1; idx = 2; end
      8'h31: begin op = 1; idx = 3; end
      8'h02: begin op = 2; idx = 0; end
      8'h0B: begin op = 3; idx = 0; end
      default: ;
    endcase
`endif
    legal = (op < 2) ? (idx < NUM_REGS) : (idx == 0);
  endfunction

  task automatic cmp_events(input string tag, input ev_t obs[$], input ev_t exp[$], input bit with_val);
    check({tag, "_count"}, 128'(obs.size()), 128'(exp.size()));
    for (int k = 0; k < obs.size() && k < exp.size(); k++) begin
      check({tag, "_edge"}, 128'(obs[k].edge_n), 128'(exp[k].edge_n));
      if (with_val) check({tag, "_val"}, 128'(obs[k].val), 128'(exp[k].val));
    end
  endtask

  // One frame: cmd, optional address/dummy, nwords data words; cut>=0 truncates the frame in bits
  task automatic frame(input logic [7:0] cmd, input logic [31:0] addr, input int nwords,
                       input logic [31:0] w0, input int cut);
    int          op, idx, hdr, n, err_cnt, exp_state;
    bit          legal, mem;
    logic [31:0] words[$];
    logic [31:0] w;
    bit          bits[$];
    ev_t         etx[$], erx[$], eav[$], otx[$], orx[$], oav[$];

    model_decode(cmd, op, idx, legal);
    mem = (op >= 2);
    hdr = 8 + (mem ? ADDR_W : 0) + ((op == 3) ? DUMMY_CYC : 0);
    for (int k = 0; k < nwords; k++) words.push_back((k == 0) ? w0 : $urandom());
    for (int i = 7; i >= 0; i--) bits.push_back(cmd[i]);
    if (mem) for (int i = ADDR_W - 1; i >= 0; i--) bits.push_back(addr[i]);
    if (op == 3) for (int i = 0; i < DUMMY_CYC; i++) bits.push_back(bit'($urandom_range(0, 1)));
    foreach (words[k]) begin
      w = words[k];
      for (int i = DATA_W - 1; i >= 0; i--) bits.push_back(w[i]);
    end
    if (!mem) repeat (5) bits.push_back(bit'($urandom_range(0, 1)));
    n = (cut >= 0 && cut < bits.size()) ? cut : bits.size();

    // Expected strobes as (edge number, value) lists
    if (legal && !mem) begin
      if (op == 1) etx.push_back('{8, 32'h0});
      if (op == 0 && n >= 8 + DATA_W) erx.push_back('{8 + DATA_W, words[0]});
    end else if (legal) begin
      if (n >= 8 + ADDR_W) eav.push_back('{8 + ADDR_W, addr});
      if (n >= hdr) etx.push_back('{hdr, 32'h0});
      for (int k = 1; hdr + DATA_W * k <= n; k++) begin
        eav.push_back('{hdr + DATA_W * k, addr + 32'(4 * k)});
        if (op == 2) erx.push_back('{hdr + DATA_W * k, words[k-1]});
        if (op == 3) etx.push_back('{hdr + DATA_W * k, 32'h0});
      end
    end
    exp_state = !legal ? 4 : (mem ? 1 : 3);

    err_cnt = 0;
    @(negedge sclk);
    cs_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      sdi = bits[i];
      @(posedge sclk);
      #1;
      if (tx_load_o)    otx.push_back('{i + 1, 32'h0});
      if (rx_valid_o)   orx.push_back('{i + 1, rx_data_o});
      if (addr_valid_o) oav.push_back('{i + 1, addr_o});
      if (error_o)      err_cnt++;
      if (i == 7) begin
        check("state_after_opcode", 128'(state_o), 128'(exp_state));
        check("op_flags", 128'({is_mem_o, is_read_o}), 128'(op));
        check("reg_sel", 128'(reg_sel_o), 128'(idx));
      end
      @(negedge sclk);
    end
    cs_n = 1'b1;
    sdi  = 1'b0;

    cmp_events("tx_load", otx, etx, 1'b0);
    cmp_events("rx_valid", orx, erx, 1'b1);
    cmp_events("addr_valid", oav, eav, 1'b1);
    check("error_cycles", 128'(err_cnt), 128'((!legal && n >= 8) ? n - 7 : 0));

    if (n >= 8) last_sel = 6'(idx);
    if (eav.size() > 0) last_addr = eav[eav.size()-1].val;
    if (erx.size() > 0) last_rx = erx[erx.size()-1].val;

    @(posedge sclk);
    #1;
    check("end_state", 128'(state_o), 128'(0));
    check("end_strobes", 128'({error_o, rx_valid_o, tx_load_o, addr_valid_o}), 128'(0));
    check("hold_sel", 128'(reg_sel_o), 128'(last_sel));
    check("hold_addr", 128'(addr_o), 128'(last_addr));
    check("hold_rx", 128'(rx_data_o), 128'(last_rx));
  endtask

  logic [7:0] rand_cmds [8];

  initial begin
    rand_cmds = '{8'h00, 8'h41, 8'h80, 8'hC0, 8'h03, 8'h45, 8'h81, 8'h22};

    // Power-on reset
    #1 rstn = 1'b0;
    #2;
    check("reset_state", 128'(state_o), 128'(0));
    check("reset_outputs", 128'({reg_sel_o, is_mem_o, is_read_o, addr_o, addr_valid_o,
                                 rx_data_o, rx_valid_o, tx_load_o, error_o}), 128'(0));
    repeat (2) @(negedge sclk);
    rstn = 1'b1;

    // Directed frames
    frame(8'h03, 32'h0, 1, 32'hDEADBEEF, -1);
    frame(8'hC0, 32'h0000_1000, 3, $urandom(), -1);
    frame(8'h80, 32'hFFFF_FFFC, 2, $urandom(), -1);
    frame(8'h05, 32'h0, 1, $urandom(), -1);
    frame(8'h01, 32'h0, 1, $urandom(), 8 + 20);
    frame(8'h42, 32'h0, 1, $urandom(), -1);
    frame(8'h8C, 32'h1234_5678, 1, $urandom(), -1);
    frame(8'h80, 32'h0000_0040, 2, $urandom(), 8 + 32 + 32 + 20);

    // Randomised frames
    for (int r = 0; r < 10; r++) begin
      frame(rand_cmds[$urandom_range(0, 7)], $urandom(), int'($urandom_range(1, 3)), $urandom(),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(9, 100)) : -1);
    end

    // Asynchronous reset in the middle of a register write data phase
    @(negedge sclk);
    cs_n = 1'b0;
    for (int i = 0; i < 18; i++) begin
      sdi = (i < 8) ? ((8'h02 >> (7 - i)) & 1) : 1'b1;
      @(negedge sclk);
    end
    check("pre_reset_state", 128'(state_o), 128'(3));
    @(posedge sclk);
    #2 rstn = 1'b0;
    #1;
    check("async_reset_state", 128'(state_o), 128'(0));
    check("async_reset_outputs", 128'({reg_sel_o, is_mem_o, is_read_o, addr_o, addr_valid_o,
                                       rx_data_o, rx_valid_o, tx_load_o, error_o}), 128'(0));
    @(negedge sclk);
    cs_n = 1'b1;
    rstn = 1'b1;
    last_addr = '0;
    last_rx   = '0;
    last_sel  = '0;

    // Clean frame right after reset
    frame(8'h00, 32'h0, 1, 32'hA5A5_0F0F, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
